// File: rtl/id_ex_skid_register_pkg.sv
// id_ex_skid_register_pkg: shared pipeline widths, ID/EX bundle length and skid state encodings
package id_ex_skid_register_pkg;
  localparam int ADDRESS_LEN = 32;
  localparam int REGISTER_LEN = 32;
  localparam int EXECUTE_COMMAND_LEN = 4;
  localparam int SHIFT_OPERAND_LEN = 12;
  localparam int REGFILE_ADDRESS_LEN = 4;
  localparam int SIGNED_IMMEDIATE_LEN = 24;
  localparam int CONTROL_BITS = 5;
  function automatic int id_ex_bundle_len(input int a, input int r, input int e, input int s, input int f);
    return a + CONTROL_BITS + e + 2 * r + 1 + SIGNED_IMMEDIATE_LEN + s + f;
  endfunction
  localparam int ID_EX_BUNDLE_LEN = id_ex_bundle_len(ADDRESS_LEN, REGISTER_LEN, EXECUTE_COMMAND_LEN,
                                                     SHIFT_OPERAND_LEN, REGFILE_ADDRESS_LEN);
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;
endpackage

// File: rtl/id_ex_skid_register_pipe_skid_buffer.sv
// pipe_skid_buffer: two-entry valid/ready skid register with flush; ready depends on state only
module pipe_skid_buffer
  import id_ex_skid_register_pkg::*;
#(
  parameter int WIDTH = ID_EX_BUNDLE_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  skid_state_t state, state_next;
  logic [WIDTH-1:0] main_q, skid_q;
  logic accept, drain, load_main, load_skid;
  assign in_ready = state != TWO;
  assign out_valid = state != EMPTY;
  assign out_data = main_q;
  assign accept = in_valid & in_ready;
  assign drain = out_valid & out_ready;
  // next state and payload load enables; flush overrides every handshake
  always_comb begin
    state_next = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    if (flush) state_next = EMPTY;
    else
      case (state)
        EMPTY: begin
          load_main = accept;
          state_next = accept ? ONE : EMPTY;
        end
        ONE: begin
          load_main = accept & drain;
          load_skid = accept & ~drain;
          state_next = accept ? (drain ? ONE : TWO) : (drain ? EMPTY : ONE);
        end
        TWO: begin
          load_main = drain;
          state_next = drain ? ONE : TWO;
        end
        default: state_next = EMPTY;
      endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= EMPTY;
    else state <= state_next;
  // payload registers; main refills from skid when draining out of TWO so order is kept
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) main_q <= (state == TWO) ? skid_q : in_data;
      if (load_skid) skid_q <= in_data;
    end
endmodule

// File: rtl/id_ex_skid_register.sv
// id_ex_skid_register: decode-to-execute pipeline register with skid buffer, flush and bubble masking
module id_ex_skid_register
  import id_ex_skid_register_pkg::*;
#(
  parameter int ADDRESS_LEN = id_ex_skid_register_pkg::ADDRESS_LEN,
  parameter int REGISTER_LEN = id_ex_skid_register_pkg::REGISTER_LEN,
  parameter int EXECUTE_COMMAND_LEN = id_ex_skid_register_pkg::EXECUTE_COMMAND_LEN,
  parameter int SHIFT_OPERAND_LEN = id_ex_skid_register_pkg::SHIFT_OPERAND_LEN,
  parameter int REGFILE_ADDRESS_LEN = id_ex_skid_register_pkg::REGFILE_ADDRESS_LEN
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ADDRESS_LEN-1:0]         pc_in,
  input  logic                           mem_read_in,
  input  logic                           mem_write_in,
  input  logic                           wb_enable_in,
  input  logic                           branch_taken_in,
  input  logic                           status_write_enable_in,
  input  logic [EXECUTE_COMMAND_LEN-1:0] execute_command_in,
  input  logic [REGISTER_LEN-1:0]        val_rn_in,
  input  logic [REGISTER_LEN-1:0]        val_rm_in,
  input  logic                           immediate_in,
  input  logic [23:0]                    signed_immediate_in,
  input  logic [SHIFT_OPERAND_LEN-1:0]   shift_operand_in,
  input  logic [REGFILE_ADDRESS_LEN-1:0] dest_reg_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [ADDRESS_LEN-1:0]         pc_out,
  output logic                           mem_read_out,
  output logic                           mem_write_out,
  output logic                           wb_enable_out,
  output logic                           branch_taken_out,
  output logic                           status_write_enable_out,
  output logic [EXECUTE_COMMAND_LEN-1:0] execute_command_out,
  output logic [REGISTER_LEN-1:0]        val_rn_out,
  output logic [REGISTER_LEN-1:0]        val_rm_out,
  output logic                           immediate_out,
  output logic [23:0]                    signed_immediate_out,
  output logic [SHIFT_OPERAND_LEN-1:0]   shift_operand_out,
  output logic [REGFILE_ADDRESS_LEN-1:0] dest_reg_out
);
  localparam int BUNDLE_LEN = id_ex_bundle_len(ADDRESS_LEN, REGISTER_LEN, EXECUTE_COMMAND_LEN,
                                               SHIFT_OPERAND_LEN, REGFILE_ADDRESS_LEN);
  logic [BUNDLE_LEN-1:0] in_bundle, out_bundle;
  logic [CONTROL_BITS-1:0] ctrl_q;
  logic [EXECUTE_COMMAND_LEN-1:0] cmd_q;
  assign in_bundle = {pc_in, mem_read_in, mem_write_in, wb_enable_in, branch_taken_in,
                      status_write_enable_in, execute_command_in, val_rn_in, val_rm_in,
                      immediate_in, signed_immediate_in, shift_operand_in, dest_reg_in};
  pipe_skid_buffer #(.WIDTH(BUNDLE_LEN)) u_skid (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_bundle),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_bundle)
  );
  assign {pc_out, ctrl_q, cmd_q, val_rn_out, val_rm_out, immediate_out, signed_immediate_out,
          shift_operand_out, dest_reg_out} = out_bundle;
  // bubbles carry no side effects into execute: control and ALU command forced low
  assign {mem_read_out, mem_write_out, wb_enable_out, branch_taken_out, status_write_enable_out} =
      out_valid ? ctrl_q : '0;
  assign execute_command_out = out_valid ? cmd_q : '0;
endmodule

// File: tb/tb_id_ex_skid_register.sv
// tb_id_ex_skid_register: scoreboard-driven self-checking bench for id_ex_skid_register
module tb_id_ex_skid_register;
  typedef struct packed {
    logic [31:0] pc;
    logic        mem_read;
    logic        mem_write;
    logic        wb;
    logic        br;
    logic        sw;
    logic [3:0]  cmd;
    logic [31:0] rn;
    logic [31:0] rm;
    logic        imm;
    logic [23:0] simm;
    logic [11:0] sh;
    logic [3:0]  rd;
  } bundle_t;
  logic clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic mem_read_out, mem_write_out, wb_enable_out, branch_taken_out, status_write_enable_out;
  logic immediate_out;
  logic [3:0] execute_command_out, dest_reg_out;
  logic [23:0] signed_immediate_out;
  logic [11:0] shift_operand_out;
  bundle_t cur = '0, obs, exp_b;
  bundle_t q[$];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  assign obs = {pc_out, mem_read_out, mem_write_out, wb_enable_out, branch_taken_out,
                status_write_enable_out, execute_command_out, val_rn_out, val_rm_out,
                immediate_out, signed_immediate_out, shift_operand_out, dest_reg_out};
  id_ex_skid_register dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(cur.pc), .mem_read_in(cur.mem_read), .mem_write_in(cur.mem_write),
    .wb_enable_in(cur.wb), .branch_taken_in(cur.br), .status_write_enable_in(cur.sw),
    .execute_command_in(cur.cmd), .val_rn_in(cur.rn), .val_rm_in(cur.rm),
    .immediate_in(cur.imm), .signed_immediate_in(cur.simm), .shift_operand_in(cur.sh),
    .dest_reg_in(cur.rd), .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out), .wb_enable_out(wb_enable_out),
    .branch_taken_out(branch_taken_out), .status_write_enable_out(status_write_enable_out),
    .execute_command_out(execute_command_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .immediate_out(immediate_out), .signed_immediate_out(signed_immediate_out),
    .shift_operand_out(shift_operand_out), .dest_reg_out(dest_reg_out)
  );
  task automatic rand_bundle(input logic [31:0] pc);
    cur = bundle_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
    cur.pc = pc;
  endtask
  task automatic tick();
    #1;
    if (flush) q.delete();
    else begin
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got output pc=%h, required no output", pc_out);
        end else begin
          exp_b = q.pop_front();
          if (obs !== exp_b) begin
            errors++;
            $display("FAIL sb_bundle: got %h, required %h", obs, exp_b);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(cur);
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== '0) begin
      errors++;
      $display("FAIL reset: got valid=%b ready=%b bundle=%h, required 0 1 0", out_valid, in_ready, obs);
    end
    repeat (2) @(negedge clk);
    rst = 1;
  endtask
  task automatic test_first_transfer();
    cur = '0;
    cur.pc = 32'h4;
    cur.wb = 1;
    in_valid = 1;
    out_ready = 1;
    tick();
    in_valid = 0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || pc_out !== 32'h4 || wb_enable_out !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL first: got valid=%b pc=%h wb=%b ready=%b, required 1 4 1 1",
               out_valid, pc_out, wb_enable_out, in_ready);
    end
    tick();
  endtask
  task automatic test_skid_order();
    out_ready = 0;
    in_valid = 1;
    rand_bundle(32'h8);
    tick();
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL skid_one_ready: got %b, required 1", in_ready);
    end
    rand_bundle(32'hC);
    tick();
    in_valid = 0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || pc_out !== 32'h8) begin
      errors++;
      $display("FAIL skid_full: got ready=%b pc=%h, required 0 8", in_ready, pc_out);
    end
    out_ready = 1;
    tick();
    #1;
    checks++;
    if (pc_out !== 32'hC || in_ready !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL skid_second: got pc=%h ready=%b valid=%b, required C 1 1", pc_out, in_ready, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL skid_drained: got valid=%b pending=%0d, required 0 0", out_valid, q.size());
    end
  endtask
  task automatic test_back_to_back();
    int n = 0, stalls = 0;
    out_ready = 1;
    for (int i = 0; i < 11; i++) begin
      in_valid = i < 10;
      if (i < 10) rand_bundle(32'h100 + 32'(4 * i));
      #1;
      if (out_valid) n++;
      if (!in_ready) stalls++;
      tick();
    end
    in_valid = 0;
    checks++;
    if (n != 10 || stalls != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream: got outputs=%0d stalls=%0d valid=%b, required 10 0 0", n, stalls, out_valid);
    end
  endtask
  task automatic test_flush();
    int leaks = 0;
    out_ready = 0;
    in_valid = 1;
    rand_bundle(32'h200);
    cur.mem_write = 1;
    tick();
    rand_bundle(32'h204);
    cur.mem_write = 1;
    tick();
    rand_bundle(32'h208);
    flush = 1;
    tick();
    flush = 0;
    in_valid = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || mem_write_out !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_two: got valid=%b mem_write=%b ready=%b, required 0 0 1",
               out_valid, mem_write_out, in_ready);
    end
    in_valid = 1;
    rand_bundle(32'h20C);
    tick();
    rand_bundle(32'h210);
    flush = 1;
    tick();
    flush = 0;
    in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (out_valid) leaks++;
      tick();
    end
    checks++;
    if (leaks != 0) begin
      errors++;
      $display("FAIL flush_leak: got %0d flushed outputs, required 0", leaks);
    end
  endtask
  task automatic test_bubble();
    out_ready = 1;
    rand_bundle(32'h400);
    {cur.mem_read, cur.mem_write, cur.wb, cur.br, cur.sw, cur.cmd} = '1;
    in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    #1;
    checks++;
    if (out_valid !== 1'b0 || {mem_read_out, mem_write_out, wb_enable_out, branch_taken_out,
        status_write_enable_out, execute_command_out} !== 9'h0) begin
      errors++;
      $display("FAIL bubble: got valid=%b ctrl=%b cmd=%h, required 0 00000 0", out_valid,
               {mem_read_out, mem_write_out, wb_enable_out, branch_taken_out, status_write_enable_out},
               execute_command_out);
    end
  endtask
  task automatic test_async_reset();
    out_ready = 0;
    in_valid = 1;
    rand_bundle(32'h500);
    tick();
    rand_bundle(32'h504);
    tick();
    in_valid = 0;
    @(posedge clk);
    #2 rst = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || obs !== '0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b ready=%b bundle=%h, required 0 1 0", out_valid, in_ready, obs);
    end
    q.delete();
    @(negedge clk);
    rst = 1;
    rand_bundle(32'h600);
    in_valid = 1;
    tick();
    in_valid = 0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || pc_out !== 32'h600) begin
      errors++;
      $display("FAIL post_reset: got valid=%b pc=%h, required 1 600", out_valid, pc_out);
    end
    out_ready = 1;
    tick();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL post_reset_drain: got %0d pending, required 0", q.size());
    end
  endtask
  initial begin
    test_reset();
    test_first_transfer();
    test_skid_order();
    test_back_to_back();
    test_flush();
    test_bubble();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
